// File: rtl/rename_map_table.sv
// Register alias table: 32 architectural -> 64 physical mappings plus per-PR ready bits.
// Define RMT_WB_BYPASS_EN to forward a same-cycle writeback into the source ready outputs.
module rename_map_table #(
    parameter int unsigned NUM_AR = 32,
    parameter int unsigned NUM_PR = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [$clog2(NUM_AR)-1:0] rs,
    input  logic [$clog2(NUM_AR)-1:0] rt,
    input  logic [$clog2(NUM_AR)-1:0] rd,
    input  logic                      RegDest,
    input  logic [$clog2(NUM_PR)-1:0] PR_new,
    input  logic                      empty,
    input  logic                      stall_recover,
    input  logic                      recover,
    input  logic [$clog2(NUM_AR)-1:0] rec_rd,
    input  logic [$clog2(NUM_PR)-1:0] rec_PR_old,
    input  logic                      wb_en,
    input  logic [$clog2(NUM_PR)-1:0] wb_PR,
    output logic [$clog2(NUM_PR)-1:0] PR_rs,
    output logic [$clog2(NUM_PR)-1:0] PR_rt,
    output logic [$clog2(NUM_PR)-1:0] PR_old,
    output logic                      rs_ready,
    output logic                      rt_ready,
    output logic                      alloc,
    output logic                      rename_stall
);

    localparam int unsigned PrW = $clog2(NUM_PR);

    logic [PrW-1:0]    map_q [NUM_AR];
    logic [PrW-1:0]    map_d [NUM_AR];
    logic [NUM_PR-1:0] rdy_q;
    logic [NUM_PR-1:0] rdy_d;
    logic              rd_valid;
    logic              wb_fire;

    assign rd_valid     = RegDest && (rd != '0);
    assign alloc        = rd_valid && !empty && !stall_recover && !recover;
    assign rename_stall = rd_valid && !alloc;
    assign wb_fire      = wb_en && !stall_recover;

    assign PR_rs  = map_q[rs];
    assign PR_rt  = map_q[rt];
    assign PR_old = map_q[rd];

`ifdef RMT_WB_BYPASS_EN
    assign rs_ready = rdy_q[PR_rs] || (wb_fire && (wb_PR == PR_rs));
    assign rt_ready = rdy_q[PR_rt] || (wb_fire && (wb_PR == PR_rt));
`else
    assign rs_ready = rdy_q[PR_rs];
    assign rt_ready = rdy_q[PR_rt];
`endif

    always_comb begin
        map_d = map_q;
        rdy_d = rdy_q;
        if (wb_fire) begin
            rdy_d[wb_PR] = 1'b1;
        end
        // Rename clear is applied after writeback so it wins on a collision; PR0 stays ready.
        if (alloc) begin
            map_d[rd] = PR_new;
            if (PR_new != '0) begin
                rdy_d[PR_new] = 1'b0;
            end
        end
        if (recover && (rec_rd != '0)) begin
            map_d[rec_rd] = rec_PR_old;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_AR; i++) begin
                map_q[i] <= PrW'(i);
            end
            rdy_q <= '1;
        end else begin
            map_q <= map_d;
            rdy_q <= rdy_d;
        end
    end

    a_no_clear_set_collision: assert property (@(posedge clk) disable iff (rst)
        !(alloc && wb_fire && (wb_PR == PR_new)));

endmodule

// File: tb/tb_rename_map_table.sv
// Directed self-checking bench for rename_map_table; expectations are hand-computed.
module tb_rename_map_table;

    logic       clk;
    logic       rst;
    logic [4:0] rs, rt, rd, rec_rd;
    logic       RegDest, empty, stall_recover, recover, wb_en;
    logic [5:0] PR_new, rec_PR_old, wb_PR;
    logic [5:0] PR_rs, PR_rt, PR_old;
    logic       rs_ready, rt_ready, alloc, rename_stall;

    int checks = 0;
    int errors = 0;

`ifdef RMT_WB_BYPASS_EN
    localparam logic BypassExp = 1'b1;
`else
    localparam logic BypassExp = 1'b0;
`endif

    rename_map_table dut (
        .clk          (clk),
        .rst          (rst),
        .rs           (rs),
        .rt           (rt),
        .rd           (rd),
        .RegDest      (RegDest),
        .PR_new       (PR_new),
        .empty        (empty),
        .stall_recover(stall_recover),
        .recover      (recover),
        .rec_rd       (rec_rd),
        .rec_PR_old   (rec_PR_old),
        .wb_en        (wb_en),
        .wb_PR        (wb_PR),
        .PR_rs        (PR_rs),
        .PR_rt        (PR_rt),
        .PR_old       (PR_old),
        .rs_ready     (rs_ready),
        .rt_ready     (rt_ready),
        .alloc        (alloc),
        .rename_stall (rename_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        rst = 1'b0; rs = '0; rt = '0; rd = '0; rec_rd = '0;
        RegDest = 1'b0; empty = 1'b0; stall_recover = 1'b0; recover = 1'b0; wb_en = 1'b0;
        PR_new = '0; rec_PR_old = '0; wb_PR = '0;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1'b1;
        step();
        rst = 1'b0; rs = 5'd3; rt = 5'd4;
        #1;
        checks++; if (PR_rs !== 6'd3) begin errors++; $display("FAIL reset_pr_rs got %0d want 3", PR_rs); end
        checks++; if (PR_rt !== 6'd4) begin errors++; $display("FAIL reset_pr_rt got %0d want 4", PR_rt); end
        checks++; if (rs_ready !== 1'b1 || rt_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b%b want 11", rs_ready, rt_ready); end
        checks++; if (alloc !== 1'b0 || rename_stall !== 1'b0) begin errors++; $display("FAIL reset_alloc got %b%b want 00", alloc, rename_stall); end
    endtask

    task automatic test_rename();
        set_idle();
        RegDest = 1'b1; rd = 5'd5; PR_new = 6'd32;
        #1;
        checks++; if (alloc !== 1'b1 || rename_stall !== 1'b0) begin errors++; $display("FAIL rename_alloc got %b%b want 10", alloc, rename_stall); end
        checks++; if (PR_old !== 6'd5) begin errors++; $display("FAIL rename_pr_old got %0d want 5", PR_old); end
        step();
        RegDest = 1'b0; rs = 5'd5;
        #1;
        checks++; if (PR_rs !== 6'd32) begin errors++; $display("FAIL rename_map got %0d want 32", PR_rs); end
        checks++; if (rs_ready !== 1'b0) begin errors++; $display("FAIL rename_not_ready got %b want 0", rs_ready); end
        wb_en = 1'b1; wb_PR = 6'd32;
        #1;
        checks++; if (rs_ready !== BypassExp) begin errors++; $display("FAIL wb_same_cycle got %b want %b", rs_ready, BypassExp); end
        step();
        wb_en = 1'b0;
        #1;
        checks++; if (rs_ready !== 1'b1) begin errors++; $display("FAIL wb_next_cycle got %b want 1", rs_ready); end
    endtask

    task automatic test_hazard();
        set_idle();
        RegDest = 1'b1; rd = 5'd7; rs = 5'd7; PR_new = 6'd40;
        #1;
        checks++; if (PR_rs !== 6'd7 || rs_ready !== 1'b1) begin errors++; $display("FAIL hazard_old got %0d/%b want 7/1", PR_rs, rs_ready); end
        checks++; if (alloc !== 1'b1) begin errors++; $display("FAIL hazard_alloc got %b want 1", alloc); end
        step();
        RegDest = 1'b0;
        #1;
        checks++; if (PR_rs !== 6'd40 || rs_ready !== 1'b0) begin errors++; $display("FAIL hazard_new got %0d/%b want 40/0", PR_rs, rs_ready); end
    endtask

    task automatic test_blocked();
        set_idle();
        RegDest = 1'b1; rd = 5'd0; rs = 5'd0; PR_new = 6'd41;
        #1;
        checks++; if (alloc !== 1'b0 || rename_stall !== 1'b0) begin errors++; $display("FAIL ar0_alloc got %b%b want 00", alloc, rename_stall); end
        step();
        RegDest = 1'b0;
        #1;
        checks++; if (PR_rs !== 6'd0 || rs_ready !== 1'b1) begin errors++; $display("FAIL ar0_map got %0d/%b want 0/1", PR_rs, rs_ready); end
        RegDest = 1'b1; rd = 5'd9; empty = 1'b1; PR_new = 6'd42;
        #1;
        checks++; if (alloc !== 1'b0 || rename_stall !== 1'b1) begin errors++; $display("FAIL empty_stall got %b%b want 01", alloc, rename_stall); end
        step();
        RegDest = 1'b0; empty = 1'b0; rs = 5'd9;
        #1;
        checks++; if (PR_rs !== 6'd9 || rs_ready !== 1'b1) begin errors++; $display("FAIL empty_map got %0d/%b want 9/1", PR_rs, rs_ready); end
        // stall_recover blocks both rename and writeback marking
        RegDest = 1'b1; rd = 5'd9; stall_recover = 1'b1; wb_en = 1'b1; wb_PR = 6'd40; PR_new = 6'd43;
        #1;
        checks++; if (alloc !== 1'b0 || rename_stall !== 1'b1) begin errors++; $display("FAIL stallrec_alloc got %b%b want 01", alloc, rename_stall); end
        step();
        set_idle();
        rs = 5'd9; rt = 5'd7;
        #1;
        checks++; if (PR_rs !== 6'd9) begin errors++; $display("FAIL stallrec_map got %0d want 9", PR_rs); end
        checks++; if (PR_rt !== 6'd40 || rt_ready !== 1'b0) begin errors++; $display("FAIL stallrec_wb got %0d/%b want 40/0", PR_rt, rt_ready); end
    endtask

    task automatic test_recover();
        set_idle();
        RegDest = 1'b1; rd = 5'd5; PR_new = 6'd33;
        #1;
        checks++; if (PR_old !== 6'd32 || alloc !== 1'b1) begin errors++; $display("FAIL rec_rename got %0d/%b want 32/1", PR_old, alloc); end
        step();
        RegDest = 1'b1; rd = 5'd10; PR_new = 6'd34;
        recover = 1'b1; rec_rd = 5'd5; rec_PR_old = 6'd32;
        wb_en = 1'b1; wb_PR = 6'd40;
        #1;
        checks++; if (alloc !== 1'b0 || rename_stall !== 1'b1) begin errors++; $display("FAIL rec_blocks_alloc got %b%b want 01", alloc, rename_stall); end
        step();
        set_idle();
        recover = 1'b1; rec_rd = 5'd5; rec_PR_old = 6'd5;
        rs = 5'd5; rt = 5'd7;
        #1;
        checks++; if (PR_rs !== 6'd32 || rs_ready !== 1'b1) begin errors++; $display("FAIL rec_step1 got %0d/%b want 32/1", PR_rs, rs_ready); end
        checks++; if (PR_rt !== 6'd40 || rt_ready !== 1'b1) begin errors++; $display("FAIL rec_with_wb got %0d/%b want 40/1", PR_rt, rt_ready); end
        rt = 5'd10;
        #1;
        checks++; if (PR_rt !== 6'd10) begin errors++; $display("FAIL rec_no_rename got %0d want 10", PR_rt); end
        step();
        recover = 1'b1; rec_rd = 5'd0; rec_PR_old = 6'd20; rs = 5'd5; rt = 5'd0;
        #1;
        checks++; if (PR_rs !== 6'd5 || rs_ready !== 1'b1) begin errors++; $display("FAIL rec_final got %0d/%b want 5/1", PR_rs, rs_ready); end
        step();
        recover = 1'b0;
        #1;
        checks++; if (PR_rt !== 6'd0) begin errors++; $display("FAIL rec_ar0 got %0d want 0", PR_rt); end
    endtask

    task automatic test_back_to_back();
        set_idle();
        RegDest = 1'b1; rd = 5'd1; PR_new = 6'd20;
        #1;
        checks++; if (PR_old !== 6'd1) begin errors++; $display("FAIL b2b_old0 got %0d want 1", PR_old); end
        step();
        rd = 5'd2; PR_new = 6'd21;
        #1;
        checks++; if (PR_old !== 6'd2) begin errors++; $display("FAIL b2b_old1 got %0d want 2", PR_old); end
        step();
        rd = 5'd1; PR_new = 6'd22;
        #1;
        checks++; if (PR_old !== 6'd20) begin errors++; $display("FAIL b2b_old2 got %0d want 20", PR_old); end
        step();
        set_idle();
        rs = 5'd1; rt = 5'd2;
        #1;
        checks++; if (PR_rs !== 6'd22 || PR_rt !== 6'd21) begin errors++; $display("FAIL b2b_map got %0d/%0d want 22/21", PR_rs, PR_rt); end
        checks++; if (rs_ready !== 1'b0 || rt_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready got %b%b want 00", rs_ready, rt_ready); end
    endtask

    task automatic test_reset_mid();
        set_idle();
        RegDest = 1'b1; rd = 5'd12; PR_new = 6'd50;
        step();
        set_idle();
        rs = 5'd12;
        #1;
        checks++; if (PR_rs !== 6'd50 || rs_ready !== 1'b0) begin errors++; $display("FAIL mid_pre got %0d/%b want 50/0", PR_rs, rs_ready); end
        rst = 1'b1; recover = 1'b1; rec_rd = 5'd12; rec_PR_old = 6'd44;
        step();
        set_idle();
        rs = 5'd12; rt = 5'd7; rd = 5'd1;
        #1;
        checks++; if (PR_rs !== 6'd12 || PR_rt !== 6'd7 || PR_old !== 6'd1) begin errors++; $display("FAIL mid_identity got %0d/%0d/%0d want 12/7/1", PR_rs, PR_rt, PR_old); end
        checks++; if (rs_ready !== 1'b1 || rt_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b%b want 11", rs_ready, rt_ready); end
        rs = 5'd2;
        #1;
        checks++; if (PR_rs !== 6'd2 || rs_ready !== 1'b1) begin errors++; $display("FAIL mid_ar2 got %0d/%b want 2/1", PR_rs, rs_ready); end
    endtask

    initial begin
        set_idle();
        test_reset();
        test_rename();
        test_hazard();
        test_blocked();
        test_recover();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
